line_fill_latency_tracker: RTL

LINE_FILL_LATENCY_TRACKER -- requirements
Module: line_fill_latency_tracker

---
 rtl/abacus_pkg.sv | 12 +
 rtl/line_fill_latency_tracker_if.sv | 24 ++
 rtl/sat_accumulator.sv | 24 ++
 rtl/line_fill_latency_tracker.sv | 116 +++++++++++
 4 files changed

// File: rtl/abacus_pkg.sv
// Shared profiler types: fill-tracker FSM states and default counter width.
package abacus_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILLING   = 2'd1,
    ST_TIMED_OUT = 2'd2
  } fill_state_e;

endpackage

// File: rtl/line_fill_latency_tracker_if.sv
// Control inputs and statistics outputs of one line-fill latency tracker.
interface line_fill_latency_tracker_if #(
  parameter int CNT_W = abacus_pkg::DEFAULT_CNT_W
);
  logic             enable;
  logic             clear;
  logic             fill_in_progress;
  logic [CNT_W-1:0] fill_count;
  logic [CNT_W-1:0] total_latency;
  logic [CNT_W-1:0] max_latency;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] timeout_count;
  logic             busy;

  modport master (
    output enable, clear, fill_in_progress,
    input  fill_count, total_latency, max_latency, last_latency, timeout_count, busy
  );

  modport slave (
    input  enable, clear, fill_in_progress,
    output fill_count, total_latency, max_latency, last_latency, timeout_count, busy
  );
endinterface

// File: rtl/sat_accumulator.sv
// Accumulator that adds inc_val when inc_en and sticks at all-ones instead of wrapping.
module sat_accumulator #(
  parameter int W = abacus_pkg::DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] inc_val,
  output logic [W-1:0] value
);
  logic [W-1:0] r_value;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_value} + {1'b0, inc_val};
  assign value = r_value;

  always_ff @(posedge clk) begin
    if (rst || clr)
      r_value <= '0;
    else if (inc_en)
      r_value <= w_sum[W] ? '1 : w_sum[W-1:0];
  end
endmodule

// File: rtl/line_fill_latency_tracker.sv
// Measures cache line-fill durations from the fill-in-progress level and keeps
// saturating count/total/max/last/timeout statistics.
module line_fill_latency_tracker
  import abacus_pkg::*;
#(
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int MAX_FILL_CYCLES = 1024
) (
  input logic                        clk,
  input logic                        rst,
  line_fill_latency_tracker_if.slave bus
);
  localparam logic [CNT_W-1:0] ONES  = '1;
  // Timeout fires on the cycle the fill length would reach MAX_FILL_CYCLES.
  localparam logic [63:0]      LIMIT = 64'(MAX_FILL_CYCLES - 1);

  fill_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cur_lat, w_cur_lat_nxt;
  logic [CNT_W-1:0] r_max_lat, r_last_lat;
  logic             r_fill_q, r_seen_low;
  logic             w_rise, w_commit, w_timeout, w_at_limit;

  // After reset fill_q is 0 even if the fill is still high; seen_low blocks
  // that false edge until the level has actually been observed low.
  assign w_rise     = bus.fill_in_progress & ~r_fill_q & r_seen_low;
  assign w_at_limit = 64'(r_cur_lat) >= LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_q   <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_fill_q <= bus.fill_in_progress;
      if (!bus.fill_in_progress) r_seen_low <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cur_lat <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_lat <= w_cur_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_lat_nxt = r_cur_lat;
    w_commit      = 1'b0;
    w_timeout     = 1'b0;
    if (bus.clear) begin
      w_state_nxt   = ST_IDLE;
      w_cur_lat_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.enable && w_rise) begin
            w_state_nxt   = ST_FILLING;
            w_cur_lat_nxt = CNT_W'(1);
          end
        end
        ST_FILLING: begin
          if (!bus.enable) begin
            w_state_nxt   = ST_IDLE;
            w_cur_lat_nxt = '0;
          end else if (!bus.fill_in_progress) begin
            w_commit      = 1'b1;
            w_state_nxt   = ST_IDLE;
            w_cur_lat_nxt = '0;
          end else if (w_at_limit) begin
            w_timeout     = 1'b1;
            w_state_nxt   = ST_TIMED_OUT;
            w_cur_lat_nxt = '0;
          end else if (r_cur_lat != ONES) begin
            w_cur_lat_nxt = r_cur_lat + CNT_W'(1);
          end
        end
        ST_TIMED_OUT: begin
          if (!bus.enable || !bus.fill_in_progress) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_max_lat  <= '0;
      r_last_lat <= '0;
    end else if (w_commit) begin
      r_last_lat <= r_cur_lat;
      if (r_cur_lat > r_max_lat) r_max_lat <= r_cur_lat;
    end
  end

  sat_accumulator #(.W(CNT_W)) u_fill_count (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .inc_en(w_commit), .inc_val(CNT_W'(1)), .value(bus.fill_count)
  );

  sat_accumulator #(.W(CNT_W)) u_total_latency (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .inc_en(w_commit), .inc_val(r_cur_lat), .value(bus.total_latency)
  );

  sat_accumulator #(.W(CNT_W)) u_timeout_count (
    .clk(clk), .rst(rst), .clr(bus.clear),
    .inc_en(w_timeout), .inc_val(CNT_W'(1)), .value(bus.timeout_count)
  );

  assign bus.max_latency  = r_max_lat;
  assign bus.last_latency = r_last_lat;
  assign bus.busy         = (r_state == ST_FILLING);
endmodule
